bytecode_byte_stream: RTL and testbench
=======================================

# bytecode_byte_stream

Byte-serialising stage directly downstream of the instruction-word fetch unit. It accepts 32-bit instruction-memory words, buffers them, and presents JVM bytecode to the decoder one byte per cycle in program order. Each byte is tagged with its bytecode address. A flush input discards buffered bytes and reloads the byte address for branch redirects.

## Interface
Parameters:
- `BUF_WORDS`, default 2: buffer capacity in 32-bit words; must be a power of two, ≥1. Capacity `CAP = 4*BUF_WORDS` bytes.
- `ADDRESS_WIDTH`, default 8: width of the bytecode byte address.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of the buffer plus reload of the byte address.
- `flush_addr`  in  ADDRESS_WIDTH  byte address of the first byte after a flush.
- `word_in`  in  32  fetched instruction word.
- `word_valid`  in  1  `word_in` is valid this cycle.
- `word_ready`  out  1  the buffer can accept a word this cycle.
- `byte_out`  out  8  head bytecode byte.
- `byte_valid`  out  1  `byte_out` is valid.
- `byte_ready`  in  1  the decoder consumes the head byte this cycle.
- `byte_addr`  out  ADDRESS_WIDTH  bytecode address of `byte_out`.
- `level`  out  `$clog2(CAP+1)`  number of bytes currently buffered.

## Operation
- **Storage:** circular array of `CAP` bytes.
  - `wr_ptr` advances by 4 per accepted word and is always word-aligned.
  - `rd_ptr` advances by 1 per consumed byte.
  - Both pointers wrap modulo `CAP`. `level` is the explicit occupancy count.
- **Byte order:** big-endian. `word_in[31:24]` goes to slot `wr_ptr`, `[23:16]` to `wr_ptr+1`, `[15:8]` to `+2`, `[7:0]` to `+3`.
- **Word push:** occurs when `word_valid & word_ready & ~flush`.
- **Byte pop:** occurs when `byte_valid & byte_ready & ~flush`.
- **Outputs:**
  - `word_ready = (CAP - level) >= 4`, decoded from registered `level` only. A same-cycle pop does not create room.
  - `byte_valid = (level != 0)`. `byte_out` = slot `rd_ptr`.
- **Level update:** `+4` on push, `-1` on pop, `+3` on simultaneous push and pop.
- **`byte_addr`:** increments by 1 on each pop and wraps modulo 2^ADDRESS_WIDTH.
- **Flush (has priority over everything):**
  - `level`, `wr_ptr` and `rd_ptr` go to 0; `byte_addr` loads `flush_addr`.
  - A word presented in the flush cycle is dropped, even if `word_ready` is high.
  - A byte presented in the flush cycle is not consumed.
  - The upstream fetch unit is redirected by the same flush. The upstream PC should load the word-aligned `flush_addr`. Unaligned redirect handling (byte skip) is out of scope: `flush_addr[1:0]` must be 0.
- **Reset:** `level = 0`, pointers 0, `byte_addr = 0`, `word_ready = 1`, `byte_valid = 0`. `byte_out` is don't-care while `byte_valid = 0`; the buffer array itself is not reset.
- No overflow or underflow is possible by construction. Pops with `level = 0` and pushes with `word_ready = 0` are ignored.

## Timing
- Word accepted at edge N: its first byte is visible with `byte_valid = 1` in the cycle after edge N (1-cycle latency).
- Sustained throughput: 1 byte/cycle output. Upstream needs 1 word per 4 cycles to keep `byte_valid` continuously high. With `BUF_WORDS = 2` this holds with no bubble when fetch latency is ≤4 cycles.
- Full (`level > CAP-4`): `word_ready = 0` until pops bring `level ≤ CAP-4`. The deassert and reassert decision is registered-state only, with no combinational path from `byte_ready` to `word_ready`.
- Flush at edge N: `byte_valid = 0` and `word_ready = 1` in cycle N+1. `byte_addr = flush_addr` from N+1.
- Reset is asynchronous assert and synchronous deassert, handled externally. State is held at reset values while `reset = 0`.

## Structure
- Shared package: byte-lane constant `BYTES_PER_WORD = 4` and the big-endian lane-index function.
- Optional sub-module `byte_ring_ram`, a `CAP × 8` array with a 4-byte aligned write and a 1-byte read. All control (pointers, `level`, `byte_addr`, flush) stays in `bytecode_byte_stream`.

## Test plan
- **Basic order:** after reset, push `0x1A2B3C4D` with `byte_ready = 1`. Required: bytes `0x1A`, `0x2B`, `0x3C`, `0x4D` on consecutive cycles, `byte_addr` 0..3, `level` 4→3→2→1→0.
- **Fill/backpressure:** `BUF_WORDS = 2`, `byte_ready = 0`, push 3 words. Required: 2 accepted, `word_ready = 0` at `level = 8`. After 1 pop (`level = 7`) `word_ready` stays 0; after 4 pops (`level = 4`) `word_ready = 1`.
- **Simultaneous push/pop:** at `level = 2`, push and pop in the same cycle. Required: `level = 5` next cycle, and byte order preserved across the pointer wrap at `CAP`.
- **Streaming:** continuous words `0x00010203`, `0x04050607`, … every 4 cycles with `byte_ready = 1`. Required: gap-free output 0x00, 0x01, 0x02, … for 32 bytes.
- **Flush mid-stream:** `level = 6` plus a word presented in the flush cycle, `flush_addr = 0x40`. Required: next cycle `level = 0`, `byte_valid = 0`, `byte_addr = 0x40`. The flush-cycle word is not stored; the next pushed word is output starting at address 0x40.
- **Async reset mid-operation:** drop `reset` between edges with `level = 5`. Required: `level = 0`, `byte_valid = 0` and `word_ready = 1` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bytecode_byte_stream_pkg.sv
// bytecode_byte_stream_pkg
//   Shared constants and helpers for the bytecode byte-serialising stage.
//   BYTES_PER_WORD : number of byte lanes in one fetched instruction word.
//   beLane()       : extracts byte lane 'lane' of a word in big-endian order
//                    (lane 0 is word[31:24], lane 3 is word[7:0]).
package bytecode_byte_stream_pkg;

  localparam int BYTES_PER_WORD = 4;

  // Lane 0 is the most significant byte, so it is the first bytecode in
  // program order.
  function automatic logic [7:0] beLane(input logic [31:0] word, input logic [1:0] lane);
    return word[(BYTES_PER_WORD - 1 - int'(lane)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/bytecode_byte_stream_ram.sv
// byte_ring_ram
//   CAP x 8 circular byte store with a 4-byte aligned write port and a
//   single-byte asynchronous read port. Holds no control state; pointers
//   are owned by bytecode_byte_stream. The array is intentionally not reset.
// Ports:
//   clk      : clock, write on rising edge
//   i_we     : write enable for one full word
//   i_wrPtr  : word-aligned byte slot receiving word[31:24]
//   i_word   : instruction word to store (big-endian lanes)
//   i_rdPtr  : byte slot to read
//   o_rdByte : byte stored at i_rdPtr
module byte_ring_ram
  import bytecode_byte_stream_pkg::*;
#(
  parameter int CAP   = 8,
  parameter int PTR_W = $clog2(CAP)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_wrPtr,
  input  logic [31:0]      i_word,
  input  logic [PTR_W-1:0] i_rdPtr,
  output logic [7:0]       o_rdByte
);

  logic [7:0] r_mem [CAP];

  // The write pointer is always word aligned, so the four lane slots never
  // straddle the wrap point and a plain add is enough.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        r_mem[i_wrPtr + PTR_W'(k)] <= beLane(i_word, 2'(k));
      end
    end
  end

  assign o_rdByte = r_mem[i_rdPtr];

endmodule

// File: rtl/bytecode_byte_stream.sv
// bytecode_byte_stream
//   Buffers 32-bit instruction words from the fetch unit and hands JVM
//   bytecode to the decoder one byte per cycle, tagged with its address.
//   A flush discards everything buffered and reloads the byte address.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset
//   flush      : synchronous buffer clear + byte address reload
//   flush_addr : address of the first byte after a flush (word aligned)
//   word_in    : fetched instruction word
//   word_valid : word_in is valid
//   word_ready : buffer has room for a whole word (from registered level)
//   byte_out   : head bytecode byte
//   byte_valid : byte_out is valid
//   byte_ready : decoder consumes the head byte this cycle
//   byte_addr  : bytecode address of byte_out
//   level      : number of buffered bytes
module bytecode_byte_stream
  import bytecode_byte_stream_pkg::*;
#(
  parameter int BUF_WORDS     = 2,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic [ADDRESS_WIDTH-1:0]                      flush_addr,
  input  logic [31:0]                                   word_in,
  input  logic                                          word_valid,
  output logic                                          word_ready,
  output logic [7:0]                                    byte_out,
  output logic                                          byte_valid,
  input  logic                                          byte_ready,
  output logic [ADDRESS_WIDTH-1:0]                      byte_addr,
  output logic [$clog2(BYTES_PER_WORD*BUF_WORDS+1)-1:0] level
);

  localparam int CAP   = BYTES_PER_WORD * BUF_WORDS;
  localparam int PTR_W = $clog2(CAP);
  localparam int LVL_W = $clog2(CAP + 1);

  // Highest occupancy that still leaves room for a full word.
  localparam logic [LVL_W-1:0] ROOM_LIMIT = LVL_W'(CAP - BYTES_PER_WORD);

  logic [PTR_W-1:0]         r_wrPtr;
  logic [PTR_W-1:0]         r_rdPtr;
  logic [LVL_W-1:0]         r_level;
  logic [ADDRESS_WIDTH-1:0] r_byteAddr;

  logic w_push;
  logic w_pop;

  // Room is judged on registered occupancy only, so a byte leaving this
  // cycle never opens the door for a word in the same cycle.
  assign word_ready = (r_level <= ROOM_LIMIT);
  assign byte_valid = (r_level != '0);
  assign level      = r_level;
  assign byte_addr  = r_byteAddr;

  assign w_push = word_valid & word_ready & ~flush;
  assign w_pop  = byte_valid & byte_ready & ~flush;

  byte_ring_ram #(
    .CAP   (CAP),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk      (clk),
    .i_we     (w_push),
    .i_wrPtr  (r_wrPtr),
    .i_word   (word_in),
    .i_rdPtr  (r_rdPtr),
    .o_rdByte (byte_out)
  );

  // Pointer, occupancy and address bookkeeping. Flush wins over any push or
  // pop in the same cycle; pointers wrap naturally because CAP is 2^n.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_byteAddr <= '0;
    end else if (flush) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_level    <= '0;
      r_byteAddr <= flush_addr;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(BYTES_PER_WORD);
      end
      if (w_pop) begin
        r_rdPtr    <= r_rdPtr + PTR_W'(1);
        r_byteAddr <= r_byteAddr + ADDRESS_WIDTH'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(BYTES_PER_WORD);
        2'b01:   r_level <= r_level - LVL_W'(1);
        2'b11:   r_level <= r_level + LVL_W'(BYTES_PER_WORD - 1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_bytecode_byte_stream.sv
// tb_bytecode_byte_stream
//   Self-checking bench for bytecode_byte_stream (BUF_WORDS=2, CAP=8).
//   A byte queue plus an address counter act as the reference: words append
//   four big-endian bytes, consumed bytes leave the front, flush and reset
//   empty the queue.
module tb_bytecode_byte_stream;

  localparam int CAP = 8;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [7:0]  flush_addr;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_addr;
  logic [3:0]  level;

  int vectorCount     = 0;
  int miscompareCount = 0;

  logic [7:0] modelQ[$];
  logic [7:0] modelAddr = 8'h00;

  bytecode_byte_stream #(
    .BUF_WORDS     (2),
    .ADDRESS_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .flush_addr (flush_addr),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_addr  (byte_addr),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single point of comparison: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompareCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Compare every DUT output against the reference queue.
  task automatic compareModel();
    int n;
    n = modelQ.size();
    checkOutput("level", 32'(level), 32'(n));
    checkOutput("byte_valid", 32'(byte_valid), 32'(n != 0));
    checkOutput("word_ready", 32'(word_ready), 32'((CAP - n) >= 4));
    checkOutput("byte_addr", 32'(byte_addr), 32'(modelAddr));
    if (n != 0) checkOutput("byte_out", 32'(byte_out), 32'(modelQ[0]));
  endtask

  // Called at a falling edge: check outputs, drive one cycle of inputs,
  // advance the reference at the rising edge, return at the next falling edge.
  task automatic applyStimulus(input logic wv, input logic [31:0] w, input logic br,
                               input logic fl, input logic [7:0] fa);
    bit canPush;
    compareModel();
    word_valid = wv;
    word_in    = w;
    byte_ready = br;
    flush      = fl;
    flush_addr = fa;
    @(posedge clk);
    if (!reset) begin
      modelQ.delete();
      modelAddr = 8'h00;
    end else if (fl) begin
      modelQ.delete();
      modelAddr = fa;
    end else begin
      canPush = (CAP - modelQ.size()) >= 4;
      if (br && modelQ.size() != 0) begin
        void'(modelQ.pop_front());
        modelAddr = modelAddr + 8'h01;
      end
      if (wv && canPush) begin
        modelQ.push_back(w[31:24]);
        modelQ.push_back(w[23:16]);
        modelQ.push_back(w[15:8]);
        modelQ.push_back(w[7:0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic br);
    applyStimulus(1'b0, 32'h0, br, 1'b0, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < CAP + 1; i++) idle(1'b1);
  endtask

  initial begin
    logic [7:0] basicExp[4];
    logic [7:0] k8;
    basicExp = '{8'h1A, 8'h2B, 8'h3C, 8'h4D};

    reset      = 1'b0;
    flush      = 1'b0;
    flush_addr = 8'h00;
    word_in    = 32'h0;
    word_valid = 1'b0;
    byte_ready = 1'b0;

    #1;
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_byte_valid", 32'(byte_valid), 32'd0);
    checkOutput("rst_word_ready", 32'(word_ready), 32'd1);
    checkOutput("rst_byte_addr", 32'(byte_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Basic order: one word, four consecutive bytes.
    applyStimulus(1'b1, 32'h1A2B3C4D, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkOutput("basic_byte", 32'(byte_out), 32'(basicExp[i]));
      checkOutput("basic_addr", 32'(byte_addr), 32'(i));
      checkOutput("basic_level", 32'(level), 32'(4 - i));
      idle(1'b1);
    end
    checkOutput("basic_empty", 32'(byte_valid), 32'd0);

    // Fill and backpressure: third word must be refused.
    applyStimulus(1'b1, 32'h11223344, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 32'h55667788, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 32'h99AABBCC, 1'b0, 1'b0, 8'h00);
    checkOutput("fill_level", 32'(level), 32'd8);
    checkOutput("fill_ready", 32'(word_ready), 32'd0);
    idle(1'b1);
    checkOutput("fill_ready_l7", 32'(word_ready), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    checkOutput("fill_level_l4", 32'(level), 32'd4);
    checkOutput("fill_ready_l4", 32'(word_ready), 32'd1);

    // Simultaneous push/pop at level 2 with the pointers near the wrap.
    idle(1'b1);
    idle(1'b1);
    checkOutput("sim_level_pre", 32'(level), 32'd2);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00);
    checkOutput("sim_level", 32'(level), 32'd5);
    drain();

    // Streaming: one word every four cycles gives a gap-free byte stream.
    for (int k = 0; k <= 32; k++) begin
      if (k >= 1) begin
        k8 = 8'(k - 1);
        checkOutput("stream_valid", 32'(byte_valid), 32'd1);
        checkOutput("stream_byte", 32'(byte_out), 32'(k8));
      end
      if ((k % 4) == 0 && k < 32)
        applyStimulus(1'b1, {8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3)}, 1'b1, 1'b0, 8'h00);
      else
        idle(1'b1);
    end
    drain();

    // Flush mid-stream with a word presented in the same cycle.
    applyStimulus(1'b1, 32'h01020304, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 32'h05060708, 1'b0, 1'b0, 8'h00);
    idle(1'b1);
    idle(1'b1);
    checkOutput("flush_level_pre", 32'(level), 32'd6);
    applyStimulus(1'b1, 32'hA0A1A2A3, 1'b1, 1'b1, 8'h40);
    checkOutput("flush_level", 32'(level), 32'd0);
    checkOutput("flush_valid", 32'(byte_valid), 32'd0);
    checkOutput("flush_ready", 32'(word_ready), 32'd1);
    checkOutput("flush_addr", 32'(byte_addr), 32'h40);
    applyStimulus(1'b1, 32'hCAFEBABE, 1'b0, 1'b0, 8'h00);
    checkOutput("flush_next_byte", 32'(byte_out), 32'hCA);
    checkOutput("flush_next_addr", 32'(byte_addr), 32'h40);
    drain();

    // Randomised traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 31) == 0), {6'($urandom), 2'b00});
    end

    // Asynchronous reset between edges at level 5.
    drain();
    applyStimulus(1'b1, 32'h10203040, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 32'h50607080, 1'b0, 1'b0, 8'h00);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("arst_level_pre", 32'(level), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("arst_level", 32'(level), 32'd0);
    checkOutput("arst_valid", 32'(byte_valid), 32'd0);
    checkOutput("arst_ready", 32'(word_ready), 32'd1);
    modelQ.delete();
    modelAddr = 8'h00;
    @(negedge clk);
    applyStimulus(1'b1, 32'h12345678, 1'b1, 1'b0, 8'h00);
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 8),
                    1'b0, 8'h00);
    end
    compareModel();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
    $finish;
  end

endmodule
